multicycle_controller: RTL and testbench

//  Control FSM for the multi-cycle RV32I core. Consumes op/func3/func7 from the IR and

---
 rtl/multicycle_controller_pkg.sv | 57 +++++
 rtl/multicycle_controller_alu_decoder.sv | 47 ++++
 rtl/multicycle_controller.sv | 173 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// ALU operations and datapath select codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
    S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALWB, S_LUI
  } state_e;

  // Which ALU-function table an opcode selects.
  typedef enum logic [1:0] {CLS_ADD, CLS_R, CLS_I, CLS_B} alu_class_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;

  localparam logic [1:0] SELA_PC    = 2'b00;
  localparam logic [1:0] SELA_OLDPC = 2'b01;
  localparam logic [1:0] SELA_RD1   = 2'b10;
  localparam logic [1:0] SELB_RD2   = 2'b00;
  localparam logic [1:0] SELB_IMM   = 2'b01;
  localparam logic [1:0] SELB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_S = 3'b001;
  localparam logic [2:0] EXT_B = 3'b010;
  localparam logic [2:0] EXT_J = 3'b011;
  localparam logic [2:0] EXT_U = 3'b100;

  function automatic alu_class_e op_class(input logic [6:0] op);
    case (op)
      OP_R:      return CLS_R;
      OP_I:      return CLS_I;
      OP_BRANCH: return CLS_B;
      default:   return CLS_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps (opcode class, func3, func7) to an ALU operation and flags
// function encodings the core does not implement.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  alu_class_e  cls,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  output logic [2:0]  aluop,
  output logic        illegal_func
);

  logic [3:0] key;
  logic       unused_func7;

  // Only func7[5] distinguishes add/sub; the other bits carry no meaning here.
  assign unused_func7 = ^{func7[6], func7[4:0]};

  always_comb begin
    key          = {(cls == CLS_R) & func7[5], func3};
    aluop        = ALU_ADD;
    illegal_func = 1'b0;
    case (cls)
      CLS_R, CLS_I: begin
        case (key)
          4'b0000: aluop = ALU_ADD;
          4'b1000: aluop = ALU_SUB;
          4'b0111: aluop = ALU_AND;
          4'b0110: aluop = ALU_OR;
          4'b0010: aluop = ALU_SLT;
          4'b0011: aluop = ALU_SLTU;
          4'b0100: aluop = ALU_XOR;
          default: illegal_func = 1'b1;
        endcase
      end
      CLS_B: begin
        aluop = ALU_SUB;
        case (func3)
          3'b000, 3'b001, 3'b100, 3'b101: illegal_func = 1'b0;
          default:                        illegal_func = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every select and write enable of the datapath.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       neg,
  output logic       pcwrite,
  output logic       adrsel,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] alusela,
  output logic [1:0] aluselb,
  output logic [2:0] aluop,
  output logic [1:0] resultsel,
  output logic [2:0] extend_func,
  output logic       illegal
);

  state_e     state_reg, state_next, state_cur;
  alu_class_e cls;
  logic [2:0] dec_aluop;
  logic       dec_illegal;
  logic       taken;

  assign cls = op_class(op);

  alu_decoder u_alu_decoder (
    .cls          (cls),
    .func3        (func3),
    .func7        (func7),
    .aluop        (dec_aluop),
    .illegal_func (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = neg;
      3'b101:  taken = ~neg;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    // During reset the outputs decode as FETCH, with all writes suppressed below.
    state_cur   = rst ? S_FETCH : state_reg;
    state_next  = S_FETCH;
    pcwrite     = 1'b0;
    adrsel      = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regwrite    = 1'b0;
    alusela     = SELA_PC;
    aluselb     = SELB_RD2;
    aluop       = ALU_ADD;
    resultsel   = RES_ALUOUT;
    extend_func = EXT_I;
    illegal     = 1'b0;
    case (state_cur)
      S_FETCH: begin
        irwrite    = 1'b1;
        pcwrite    = 1'b1;
        aluselb    = SELB_FOUR;
        resultsel  = RES_ALU;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alusela     = SELA_OLDPC;
        aluselb     = SELB_IMM;
        extend_func = EXT_B;
        if (dec_illegal) begin
          illegal = 1'b1;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: state_next = S_MEMADR;
            OP_R:              state_next = S_EXEC_R;
            OP_I:              state_next = S_EXEC_I;
            OP_BRANCH:         state_next = S_BRANCH;
            OP_JAL:            state_next = S_JAL;
            OP_JALR:           state_next = S_JALR;
            OP_LUI:            state_next = S_LUI;
            default:           illegal    = 1'b1;
          endcase
        end
      end
      S_MEMADR: begin
        alusela     = SELA_RD1;
        aluselb     = SELB_IMM;
        extend_func = (op == OP_LOAD) ? EXT_I : EXT_S;
        state_next  = (op == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adrsel     = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        resultsel = RES_MDR;
        regwrite  = 1'b1;
      end
      S_MEMWR: begin
        adrsel   = 1'b1;
        memwrite = 1'b1;
      end
      S_EXEC_R: begin
        alusela    = SELA_RD1;
        aluselb    = SELB_RD2;
        aluop      = dec_aluop;
        state_next = S_ALUWB;
      end
      S_EXEC_I: begin
        alusela    = SELA_RD1;
        aluselb    = SELB_IMM;
        aluop      = dec_aluop;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusela = SELA_RD1;
        aluselb = SELB_RD2;
        aluop   = ALU_SUB;
        pcwrite = taken;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut while the ALU forms the link value.
        alusela    = SELA_OLDPC;
        aluselb    = SELB_FOUR;
        pcwrite    = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        alusela    = SELA_RD1;
        aluselb    = SELB_IMM;
        state_next = S_JALWB;
      end
      S_JALWB: begin
        alusela    = SELA_OLDPC;
        aluselb    = SELB_FOUR;
        resultsel  = RES_ALU;
        pcwrite    = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        resultsel   = RES_IMM;
        extend_func = EXT_U;
        regwrite    = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pcwrite  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected output
// sequences are built from the instruction-level behaviour and compared cycle by cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'b0;
  logic [2:0] func3 = 3'b0;
  logic [6:0] func7 = 7'b0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  logic       pcwrite, adrsel, memwrite, irwrite, regwrite, illegal;
  logic [1:0] alusela, aluselb, resultsel;
  logic [2:0] aluop, extend_func;

  int checks = 0;
  int errors = 0;

  // {pcwrite,adrsel,memwrite,irwrite,regwrite,alusela,aluselb,aluop,resultsel,extend_func,illegal}
  logic [17:0] obs;
  logic [17:0] exp_q[$];

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .zero(zero), .neg(neg), .pcwrite(pcwrite), .adrsel(adrsel),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusela(alusela), .aluselb(aluselb), .aluop(aluop),
    .resultsel(resultsel), .extend_func(extend_func), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs = {pcwrite, adrsel, memwrite, irwrite, regwrite, alusela, aluselb,
                aluop, resultsel, extend_func, illegal};

  function automatic logic [17:0] mk(input logic pw, input logic as, input logic mw,
                                     input logic iw, input logic rw, input logic [1:0] a,
                                     input logic [1:0] b, input logic [2:0] alu,
                                     input logic [1:0] res, input logic [2:0] ext,
                                     input logic ill);
    return {pw, as, mw, iw, rw, a, b, alu, res, ext, ill};
  endfunction

  function automatic logic [17:0] fetch_vec();
    return mk(1, 0, 0, 1, 0, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000, 0);
  endfunction

  function automatic logic [17:0] reset_vec();
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000, 0);
  endfunction

  // ALU function table: key is {func7[5], func3}.
  function automatic logic alu_ref(input logic [3:0] key, output logic [2:0] code);
    code = 3'b000;
    case (key)
      4'b0000: code = 3'b000;
      4'b1000: code = 3'b001;
      4'b0111: code = 3'b010;
      4'b0110: code = 3'b011;
      4'b0010: code = 3'b100;
      4'b0011: code = 3'b101;
      4'b0100: code = 3'b110;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Builds the expected per-cycle output list for one instruction.
  function automatic void build(input logic [6:0] o, input logic [2:0] f3,
                                input logic [6:0] f7, input logic z, input logic n);
    logic       ok;
    logic       tk;
    logic [2:0] code;
    logic [17:0] wb;
    wb = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0);
    exp_q.delete();
    exp_q.push_back(fetch_vec());
    ok = 1'b1;
    code = 3'b000;
    case (o)
      7'b0110011: ok = alu_ref({f7[5], f3}, code);
      7'b0010011: ok = alu_ref({1'b0, f3}, code);
      7'b1100011: ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
      7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111, 7'b0110111: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 2'b00, 3'b010, !ok));
    if (!ok) return;
    case (o)
      7'b0000011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000, 0));
        exp_q.push_back(mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000, 0));
      end
      7'b0100011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b001, 0));
        exp_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0));
      end
      7'b0110011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b00, code, 2'b00, 3'b000, 0));
        exp_q.push_back(wb);
      end
      7'b0010011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, code, 2'b00, 3'b000, 0));
        exp_q.push_back(wb);
      end
      7'b1100011: begin
        tk = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : (f3 == 3'b100) ? n : !n;
        exp_q.push_back(mk(tk, 0, 0, 0, 0, 2'b10, 2'b00, 3'b001, 2'b00, 3'b000, 0));
      end
      7'b1101111: begin
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b01, 2'b10, 3'b000, 2'b00, 3'b000, 0));
        exp_q.push_back(wb);
      end
      7'b1100111: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000, 0));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b01, 2'b10, 3'b000, 2'b10, 3'b000, 0));
        exp_q.push_back(wb);
      end
      default: begin
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b11, 3'b100, 0));
      end
    endcase
  endfunction

  // Entered at a negedge with the DUT in FETCH; leaves at the next FETCH.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input logic n);
    build(o, f3, f7, z, n);
    op = o; func3 = f3; func7 = f7; zero = z; neg = n;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h required %h", name, i, obs, exp_q[i]);
      end
    end
    $display("txn %s op=%b f3=%b f7=%b zero=%b neg=%b cycles=%0d", name, o, f3, f7, z, n,
             exp_q.size());
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (obs !== reset_vec()) begin
      errors++;
      $display("FAIL reset_outputs: got %h required %h", obs, reset_vec());
    end
    checks++;
    if ({pcwrite, memwrite, irwrite, regwrite, illegal} !== 5'b0) begin
      errors++;
      $display("FAIL reset_write_enables: got %b required 00000",
               {pcwrite, memwrite, irwrite, regwrite, illegal});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== fetch_vec()) begin
      errors++;
      $display("FAIL reset_release_fetch: got %h required %h", obs, fetch_vec());
    end
    $display("txn reset released");
  endtask

  task automatic test_rtype();
    run_instr("r_sub", 7'b0110011, 3'b000, 7'b0100000, 0, 0);
    run_instr("r_and", 7'b0110011, 3'b111, 7'b0000000, 0, 0);
    run_instr("i_addi_f7", 7'b0010011, 3'b000, 7'b0100000, 0, 0);
    run_instr("i_sltiu", 7'b0010011, 3'b011, 7'b0000000, 0, 0);
  endtask

  task automatic test_mem();
    run_instr("lw", 7'b0000011, 3'b010, 7'b0000000, 0, 0);
    run_instr("sw", 7'b0100011, 3'b010, 7'b0000000, 0, 0);
  endtask

  task automatic test_branch();
    run_instr("beq_z1", 7'b1100011, 3'b000, 7'b0, 1, 0);
    run_instr("beq_z0", 7'b1100011, 3'b000, 7'b0, 0, 0);
    run_instr("blt_n1", 7'b1100011, 3'b100, 7'b0, 0, 1);
    run_instr("bge_n1", 7'b1100011, 3'b101, 7'b0, 0, 1);
    run_instr("bne_z0", 7'b1100011, 3'b001, 7'b0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_op", 7'b1111111, 3'b000, 7'b0, 0, 0);
    run_instr("illegal_slli", 7'b0010011, 3'b001, 7'b0, 0, 0);
    run_instr("illegal_branch", 7'b1100011, 3'b010, 7'b0, 1, 0);
    run_instr("jal", 7'b1101111, 3'b000, 7'b0, 0, 0);
    run_instr("jalr", 7'b1100111, 3'b000, 7'b0, 0, 0);
    run_instr("lui", 7'b0110111, 3'b000, 7'b0, 0, 0);
  endtask

  task automatic test_reset_mid();
    build(7'b0100011, 3'b010, 7'b0, 0, 0);
    op = 7'b0100011; func3 = 3'b010; func7 = 7'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL midrst_pre cycle %0d: got %h required %h", i, obs, exp_q[i]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (memwrite !== 1'b0 || obs !== reset_vec()) begin
      errors++;
      $display("FAIL midrst_memwr: got %h required %h", obs, reset_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== fetch_vec()) begin
      errors++;
      $display("FAIL midrst_fetch: got %h required %h", obs, fetch_vec());
    end
    $display("txn reset during MEMWR");
    run_instr("after_midrst_lw", 7'b0000011, 3'b010, 7'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops[8];
    logic [6:0] o;
    logic [6:0] f7;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) o = 7'($urandom);
      else o = ops[$urandom_range(0, 7)];
      f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) :
           ($urandom_range(0, 1) == 1 ? 7'b0100000 : 7'b0000000);
      run_instr("random", o, 3'($urandom), f7, 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
